// File: rtl/activation_scheduler_pkg.sv
// Shared encodings and defaults for the activation lookup scheduler.
package activation_scheduler_pkg;

  localparam logic [1:0] FUNC_SIGMOID = 2'b00;
  localparam logic [1:0] FUNC_TANH    = 2'b01;
  localparam logic [1:0] FUNC_RELU    = 2'b10;
  localparam logic [1:0] FUNC_IDENT   = 2'b11;

  localparam int DIFF_CHECK_DEF = 64;
  localparam int MAX_INDEX_DEF  = 510;

  typedef enum logic [2:0] {
    IDLE,
    READ_TAG,
    COMPARE,
    READ_ACT,
    RESP
  } state_t;

endpackage

// File: rtl/activation_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                accept,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic [ID_WIDTH-1:0] ptr;

  always_comb begin
    int idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/activation_scheduler.sv
// Arbitrates neuron requests onto the shared tag/activation ROM lookup and
// returns the selected activation with the requester id.
module activation_scheduler
  import activation_scheduler_pkg::*;
#(
  parameter int DATAWIDTH  = 16,
  parameter int INWIDTH    = 9,
  parameter int MAX_INDEX  = MAX_INDEX_DEF,
  parameter int DIFF_CHECK = DIFF_CHECK_DEF,
  parameter int NUM_REQ    = 4,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_sum,
  input  logic [2*NUM_REQ-1:0]           req_func,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATAWIDTH-1:0]           resp_value,
  output logic [DATAWIDTH-1:0]           resp_tag,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic                           tag_rd_en,
  output logic [INWIDTH-1:0]             tag_addr,
  input  logic [DATAWIDTH-1:0]           tag_data,
  output logic                           act_rd_en,
  output logic [INWIDTH-1:0]             act_addr,
  input  logic [2*DATAWIDTH-1:0]         act_data,
  output logic                           busy
);

  localparam logic [INWIDTH-1:0]          MAX_IDX  = INWIDTH'(MAX_INDEX);
  localparam logic [INWIDTH-1:0]          MID_INIT = INWIDTH'(MAX_INDEX / 2);
  localparam logic signed [DATAWIDTH:0]   DIFF_LIM = (DATAWIDTH+1)'(DIFF_CHECK);

  function automatic logic signed [DATAWIDTH-1:0] relu(input logic signed [DATAWIDTH-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic logic signed [DATAWIDTH-1:0] bypass_result(
    input logic [1:0] func, input logic signed [DATAWIDTH-1:0] x);
    return (func == FUNC_RELU) ? relu(x) : x;
  endfunction

  function automatic logic [DATAWIDTH-1:0] pick_half(
    input logic [1:0] func, input logic [2*DATAWIDTH-1:0] word);
    return (func == FUNC_TANH) ? word[DATAWIDTH-1:0] : word[2*DATAWIDTH-1:DATAWIDTH];
  endfunction

  state_t state, state_nxt;

  logic [NUM_REQ-1:0]           grant;
  logic [ID_WIDTH-1:0]          grant_id;
  logic                         accept;
  logic signed [DATAWIDTH-1:0]  sel_sum;
  logic [1:0]                   sel_func;

  logic signed [DATAWIDTH-1:0]  sum_q;
  logic [1:0]                   func_q;
  logic [ID_WIDTH-1:0]          id_q;
  logic [INWIDTH-1:0]           start_q, end_q, mid_q;
  logic [INWIDTH-1:0]           start_d, end_d, mid_d;
  logic [INWIDTH:0]             mid_sum;
  logic signed [DATAWIDTH:0]    diff;
  logic                         hit, to_act;
  logic [DATAWIDTH-1:0]         resp_value_q, resp_tag_q;
  logic                         act_fresh_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_sum  = req_sum[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
  assign sel_func = req_func[int'(grant_id)*2 +: 2];

  // Extra bit keeps the difference exact across the full signed range.
  assign diff = {sum_q[DATAWIDTH-1], sum_q} - {tag_data[DATAWIDTH-1], tag_data};
  assign hit  = (diff <= DIFF_LIM) && (diff >= -DIFF_LIM);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    to_act    = 1'b0;
    start_d   = start_q;
    end_d     = end_q;
    mid_d     = mid_q;
    mid_sum   = '0;
    case (state)
      IDLE: if (|req_valid) begin
        accept = 1'b1;
        if (sel_func[1]) begin
          state_nxt = RESP;
        end else begin
          start_d   = '0;
          end_d     = MAX_IDX;
          mid_d     = MID_INIT;
          state_nxt = READ_TAG;
        end
      end
      READ_TAG: state_nxt = COMPARE;
      COMPARE: begin
        // Edge guards stop the index from wrapping past 0 or MAX_INDEX.
        if (hit) to_act = 1'b1;
        else if (diff > 0) begin
          if (mid_q == MAX_IDX) to_act = 1'b1;
          else start_d = mid_q + 1'b1;
        end else begin
          if (mid_q == '0) to_act = 1'b1;
          else end_d = mid_q - 1'b1;
        end
        if (!to_act && (start_d > end_d)) to_act = 1'b1;
        if (to_act) begin
          state_nxt = READ_ACT;
        end else begin
          mid_sum   = {1'b0, start_d} + {1'b0, end_d};
          mid_d     = mid_sum[INWIDTH:1];
          state_nxt = READ_TAG;
        end
      end
      READ_ACT: state_nxt = RESP;
      RESP:     if (resp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sum_q        <= '0;
      func_q       <= '0;
      id_q         <= '0;
      start_q      <= '0;
      end_q        <= '0;
      mid_q        <= '0;
      resp_value_q <= '0;
      resp_tag_q   <= '0;
      act_fresh_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= start_d;
      end_q       <= end_d;
      mid_q       <= mid_d;
      act_fresh_q <= (state == READ_ACT);
      if (accept) begin
        sum_q      <= sel_sum;
        func_q     <= sel_func;
        id_q       <= grant_id;
        resp_tag_q <= '0;
        if (sel_func[1]) resp_value_q <= bypass_result(sel_func, sel_sum);
      end
      if (to_act) resp_tag_q <= tag_data;
      if (act_fresh_q) resp_value_q <= pick_half(func_q, act_data);
    end
  end

  // ROM word arrives in the first RESP cycle; forward it until it is registered.
  assign resp_value = act_fresh_q ? pick_half(func_q, act_data) : resp_value_q;
  assign resp_tag   = resp_tag_q;
  assign resp_id    = id_q;
  assign resp_valid = (state == RESP);
  assign req_ready  = (state == IDLE && reset) ? grant : '0;
  assign tag_rd_en  = (state == READ_TAG);
  assign tag_addr   = tag_rd_en ? mid_q : '0;
  assign act_rd_en  = (state == READ_ACT);
  assign act_addr   = act_rd_en ? mid_q : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler with a behavioural tag/activation ROM.
module tb_activation_scheduler;
  import activation_scheduler_pkg::*;

  localparam int W  = 16;
  localparam int IW = 9;
  localparam int NR = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*W-1:0] req_sum = '0;
  logic [2*NR-1:0] req_func = '0;
  logic [NR-1:0]  req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [W-1:0]   resp_value, resp_tag;
  logic [1:0]     resp_id;
  logic           tag_rd_en, act_rd_en, busy;
  logic [IW-1:0]  tag_addr, act_addr;
  logic [W-1:0]   tag_data = '0;
  logic [2*W-1:0] act_data = '0;

  int errors = 0;
  int checks = 0;
  int nprobe = 0;
  logic [IW-1:0] first_probe = '0, last_probe = '0;

  activation_scheduler dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_sum(req_sum), .req_func(req_func), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
    .resp_tag(resp_tag), .resp_id(resp_id),
    .tag_rd_en(tag_rd_en), .tag_addr(tag_addr), .tag_data(tag_data),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] tag_rom(input logic [IW-1:0] a);
    int v;
    v = (int'(a) - 255) * 64;
    return v[W-1:0];
  endfunction

  function automatic logic [2*W-1:0] act_rom(input logic [IW-1:0] a);
    logic [W-1:0] hi, lo;
    hi = W'(a) + 16'h1000;
    lo = W'(a) + 16'h2000;
    return {hi, lo};
  endfunction

  always @(posedge clock) begin
    if (tag_rd_en) tag_data <= tag_rom(tag_addr);
    if (act_rd_en) act_data <= act_rom(act_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (tag_rd_en) begin
      if (nprobe == 0) first_probe = tag_addr;
      last_probe = tag_addr;
      nprobe++;
    end
    if (busy) check("strobe_excl", 32'(tag_rd_en & act_rd_en), 0);
  end

  task automatic finish_resp(input string name);
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    check({name, "_idle"}, 32'(busy), 0);
  endtask

  task automatic run_job(input string name, input int id, input logic [W-1:0] sum,
                         input logic [1:0] func, input logic [W-1:0] exp_val,
                         input logic [W-1:0] exp_tag, input int exp_lat,
                         input int exp_probes, input logic [IW-1:0] exp_last);
    int cyc;
    @(negedge clock);
    nprobe = 0;
    req_sum[id*W +: W] = sum;
    req_func[id*2 +: 2] = func;
    req_valid[id] = 1'b1;
    #1 check({name, "_ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge clock); #1 req_valid[id] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!resp_valid && cyc < 200);
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_value"}, 32'(resp_value), 32'(exp_val));
    check({name, "_tag"}, 32'(resp_tag), 32'(exp_tag));
    check({name, "_id"}, 32'(resp_id), id);
    check({name, "_probes"}, nprobe, exp_probes);
    if (exp_probes > 0) begin
      check({name, "_first_probe"}, 32'(first_probe), 255);
      check({name, "_last_probe"}, 32'(last_probe), 32'(exp_last));
    end
    finish_resp(name);
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_strobes", {tag_rd_en, act_rd_en}, 0);
    check("rst_resp_value", 32'(resp_value), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(negedge clock); reset = 1'b1;

    run_job("sig_hit",  0, 16'd0,      FUNC_SIGMOID, 16'h10FF, 16'h0000, 4,  1, 9'd255);
    run_job("tanh_sat", 1, 16'd20000,  FUNC_TANH,    16'h21FE, 16'h3FC0, 20, 9, 9'd510);
    run_job("sig_low",  2, -16'sd20000, FUNC_SIGMOID, 16'h1000, 16'hC040, 20, 9, 9'd0);
    run_job("relu_pos", 2, 16'd300,    FUNC_RELU,    16'd300,  16'h0000, 1,  0, 9'd0);

    // Two concurrent ReLU requests: pointer sits at 3, so req0 wins first.
    @(negedge clock);
    req_sum[0*W +: W] = -16'sd100; req_func[0*2 +: 2] = FUNC_RELU;
    req_sum[2*W +: W] = -16'sd100; req_func[2*2 +: 2] = FUNC_RELU;
    req_valid = 4'b0101;
    #1 check("rr_first_ready", 32'(req_ready), 32'b0001);
    @(posedge clock); #1 req_valid[0] = 1'b0;
    @(negedge clock);
    check("rr_first_valid", 32'(resp_valid), 1);
    check("rr_first_id", 32'(resp_id), 0);
    check("rr_first_value", 32'(resp_value), 0);
    check("rr_no_ready_in_resp", 32'(req_ready), 0);
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    check("rr_second_ready", 32'(req_ready), 32'b0100);
    @(posedge clock); #1 req_valid[2] = 1'b0;
    @(negedge clock);
    check("rr_second_valid", 32'(resp_valid), 1);
    check("rr_second_id", 32'(resp_id), 2);
    check("rr_second_value", 32'(resp_value), 0);
    finish_resp("rr_second");

    // Back-pressure: response held for 5 cycles while another requester waits.
    @(negedge clock);
    req_sum[1*W +: W] = 16'h8123; req_func[1*2 +: 2] = FUNC_IDENT;
    req_valid[1] = 1'b1;
    #1 check("hold_ready", 32'(req_ready), 32'b0010);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    req_sum[3*W +: W] = 16'h0005; req_func[3*2 +: 2] = FUNC_IDENT;
    req_valid[3] = 1'b1;
    @(negedge clock);
    check("hold_value0", 32'(resp_value), 32'h8123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_value", 32'(resp_value), 32'h8123);
      check("hold_tag", 32'(resp_tag), 0);
      check("hold_id", 32'(resp_id), 1);
      check("hold_no_ready", 32'(req_ready), 0);
    end
    req_valid[3] = 1'b0;
    finish_resp("hold");
    check("hold_released", 32'(resp_valid), 0);

    // Reset while in COMPARE drops the job.
    @(negedge clock);
    req_sum[3*W +: W] = 16'd0; req_func[3*2 +: 2] = FUNC_SIGMOID;
    req_valid[3] = 1'b1;
    #1 check("rstjob_ready", 32'(req_ready), 32'b1000);
    @(posedge clock); #1 req_valid[3] = 1'b0;
    @(negedge clock);
    check("rstjob_read_tag", 32'(tag_rd_en), 1);
    @(negedge clock);
    check("rstjob_in_compare", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("rstjob_busy", 32'(busy), 0);
    check("rstjob_strobes", {tag_rd_en, act_rd_en}, 0);
    check("rstjob_addr", {tag_addr, act_addr}, 0);
    check("rstjob_resp", {resp_valid, resp_value, resp_tag}, 0);
    check("rstjob_id", 32'(resp_id), 0);
    @(negedge clock); reset = 1'b1;
    run_job("after_rst", 3, 16'd0, FUNC_TANH, 16'h20FF, 16'h0000, 4, 1, 9'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
